bits_needed_ctrl: RTL and testbench

- Sequencer that owns the decoder's m_bitsNeeded register and the byte feed for the CABAC arithmetic decoder.
- Drives the current bitsNeeded value into the combinational bitsNeeded datapath and takes back its request-byte flag and next value.
- Fetches bytes from the bitstream source through a one-entry buffer and hands them to the m_value shifter.
- Stalls the bin decoder with a valid/ready step handshake when a byte is needed but not yet buffered; performs slice-start initialisation.

---
 rtl/cabac_pkg.sv | 20 ++
 rtl/bits_needed_ctrl_byte_buf1.sv | 39 +++
 rtl/bits_needed_ctrl.sv | 130 +++++++++++++
 tb/tb_bits_needed_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cabac_pkg.sv
// Shared types and constants for the CABAC bitsNeeded / byte-feed sequencer.
package cabac_pkg;

  // Width of the signed m_bitsNeeded register.
  localparam int BN_W = 4;

  // Signed bitsNeeded value as seen by the datapath.
  typedef logic signed [BN_W-1:0] bn_t;

  // m_bitsNeeded value after reset and at every slice start.
  localparam int BN_RESET = -8;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/bits_needed_ctrl_byte_buf1.sv
// One-entry valid/ready byte buffer between the bitstream source and m_value.
// in_ready depends only on registers, so the source never sees a
// combinational path from the consumer side.
module byte_buf1 (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       enable,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       consume
);

  logic       buf_valid;
  logic [7:0] buf_data;

  assign in_ready  = enable & ~buf_valid;
  assign out_valid = buf_valid;
  assign out_data  = buf_data;

  // Fill on handshake, empty on consume; clear discards any held or arriving byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_data  <= '0;
    end else if (clear) begin
      buf_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      buf_valid <= 1'b1;
      buf_data  <= in_data;
    end else if (consume) begin
      buf_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/bits_needed_ctrl.sv
// Owns m_bitsNeeded and the byte feed into m_value for the CABAC decoder.
// Loads INIT_BYTES bytes at slice start, then commits decode steps, stalling
// request steps until a byte is buffered.
module bits_needed_ctrl
  import cabac_pkg::*;
#(
  parameter int INIT_BYTES = 3,
  parameter int BN_W       = 4,
  parameter int CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   init_done,
  output logic signed [BN_W-1:0] bits_needed,
  input  logic                   step_valid,
  output logic                   step_ready,
  input  logic                   dp_request_byte,
  input  logic signed [BN_W-1:0] dp_bits_needed_next,
  input  logic                   byte_valid,
  input  logic [7:0]             byte_data,
  output logic                   byte_ready,
  output logic                   value_load,
  output logic [7:0]             value_byte,
  output logic                   value_init,
  output logic                   starved,
  output logic [CNT_W-1:0]       byte_count
);

  state_t     state;
  state_t     state_next;
  logic [2:0] init_cnt;
  logic       last_init;
  logic       buf_en;
  logic       buf_valid;
  logic [7:0] buf_data;
  logic       consume;

  assign buf_en    = (state != IDLE);
  assign last_init = (init_cnt == 3'd1);

  byte_buf1 u_buf (
    .clk       (clk),
    .rst       (rst),
    .clear     (start),
    .enable    (buf_en),
    .in_valid  (byte_valid),
    .in_data   (byte_data),
    .in_ready  (byte_ready),
    .out_valid (buf_valid),
    .out_data  (buf_data),
    .consume   (consume)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: start overrides everything; INIT ends on its last byte.
  always_comb begin
    state_next = state;
    if (start) begin
      state_next = INIT;
    end else if (state == INIT && buf_valid && last_init) begin
      state_next = RUN;
    end
  end

  // Output strobes and buffer consume; start suppresses every strobe.
  always_comb begin
    busy       = (state == INIT);
    init_done  = 1'b0;
    step_ready = 1'b0;
    value_load = 1'b0;
    value_init = 1'b0;
    value_byte = buf_data;
    starved    = 1'b0;
    consume    = 1'b0;
    if (!start) begin
      unique case (state)
        INIT: begin
          if (buf_valid) begin
            value_load = 1'b1;
            value_init = 1'b1;
            consume    = 1'b1;
            init_done  = last_init;
          end
        end
        RUN: begin
          if (step_valid) begin
            if (!dp_request_byte) begin
              step_ready = 1'b1;
            end else if (buf_valid) begin
              step_ready = 1'b1;
              value_load = 1'b1;
              consume    = 1'b1;
            end else begin
              starved    = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // m_bitsNeeded: reloaded at start, otherwise changes only on a committed step.
  always_ff @(posedge clk) begin
    if (rst || start) bits_needed <= BN_W'(BN_RESET);
    else if (step_ready) bits_needed <= dp_bits_needed_next;
  end

  // Delivered-byte counter (wraps silently) and remaining-init-byte counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_count <= '0;
      init_cnt   <= '0;
    end else if (start) begin
      byte_count <= '0;
      init_cnt   <= 3'(INIT_BYTES);
    end else begin
      if (value_load) byte_count <= byte_count + 1'b1;
      if (value_load && value_init) init_cnt <= init_cnt - 3'd1;
    end
  end

endmodule

// File: tb/tb_bits_needed_ctrl.sv
// Directed self-checking bench for bits_needed_ctrl.
// Counter is narrowed to 8 bits so the wrap case is reachable in a short run.
module tb_bits_needed_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, busy, init_done;
  logic [3:0] bits_needed;
  logic       step_valid, step_ready, dp_request_byte;
  logic [3:0] dp_bits_needed_next;
  logic       byte_valid, byte_ready;
  logic [7:0] byte_data, value_byte;
  logic       value_load, value_init, starved;
  logic [7:0] byte_count;

  int errors = 0;
  int checks = 0;
  int commits;

  always #5 clk = ~clk;

  bits_needed_ctrl #(
    .INIT_BYTES (3),
    .BN_W       (4),
    .CNT_W      (8)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .busy                (busy),
    .init_done           (init_done),
    .bits_needed         (bits_needed),
    .step_valid          (step_valid),
    .step_ready          (step_ready),
    .dp_request_byte     (dp_request_byte),
    .dp_bits_needed_next (dp_bits_needed_next),
    .byte_valid          (byte_valid),
    .byte_data           (byte_data),
    .byte_ready          (byte_ready),
    .value_load          (value_load),
    .value_byte          (value_byte),
    .value_init          (value_init),
    .starved             (starved),
    .byte_count          (byte_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Feed three init bytes as fast as the buffer accepts them and check the loads.
  task automatic run_init(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] src [3];
    int sent  = 0;
    int loads = 0;
    int dones = 0;
    src = '{b0, b1, b2};
    for (int cyc = 0; cyc < 20 && loads < 3; cyc++) begin
      byte_valid = (sent < 3);
      byte_data  = (sent < 3) ? src[sent] : 8'h00;
      #2;
      if (value_load) begin
        chk("init_value", value_byte, src[loads]);
        chk("init_flag", value_init, 1);
        chk("init_done_pos", init_done, (loads == 2));
        loads++;
      end
      if (init_done) dones++;
      if (byte_valid && byte_ready) sent++;
      next_cycle();
    end
    byte_valid = 1'b0;
    chk("init_loads", loads, 3);
    chk("init_done_count", dones, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; step_valid = 1'b0; dp_request_byte = 1'b0;
    dp_bits_needed_next = 4'h0; byte_valid = 1'b0; byte_data = 8'h00;
    next_cycle();
    next_cycle();

    // Reset state
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_bn", bits_needed, 4'h8);
    chk("rst_count", byte_count, 0);
    chk("rst_byte_ready", byte_ready, 0);
    chk("rst_step_ready", step_ready, 0);
    chk("rst_value_load", value_load, 0);
    rst = 1'b0;
    next_cycle();

    // Slice start, bytes AB CD EF
    start = 1'b1;
    #2;
    chk("idle_byte_ready", byte_ready, 0);
    next_cycle();
    start = 1'b0;
    #2;
    chk("init_busy", busy, 1);
    run_init(8'hAB, 8'hCD, 8'hEF);
    #2;
    chk("run_busy", busy, 0);
    chk("run_bn", bits_needed, 4'h8);
    chk("run_count", byte_count, 3);
    next_cycle();

    // Non-request step, next = -6
    step_valid = 1'b1; dp_request_byte = 1'b0; dp_bits_needed_next = 4'hA;
    #2;
    chk("nr_ready", step_ready, 1);
    chk("nr_load", value_load, 0);
    next_cycle();
    step_valid = 1'b0;
    #2;
    chk("nr_bn", bits_needed, 4'hA);
    chk("nr_count", byte_count, 3);
    chk("nr_idle_ready", step_ready, 0);

    // Buffer 0x5A, then request step with next = -8
    byte_valid = 1'b1; byte_data = 8'h5A;
    #2;
    chk("fill_ready", byte_ready, 1);
    next_cycle();
    byte_valid = 1'b0;
    step_valid = 1'b1; dp_request_byte = 1'b1; dp_bits_needed_next = 4'h8;
    #2;
    chk("rq_ready", step_ready, 1);
    chk("rq_load", value_load, 1);
    chk("rq_byte", value_byte, 8'h5A);
    chk("rq_init", value_init, 0);
    chk("rq_starved", starved, 0);
    next_cycle();
    step_valid = 1'b0;
    #2;
    chk("rq_bn", bits_needed, 4'h8);
    chk("rq_count", byte_count, 4);

    // Starved request step, next = -5, byte arrives after 5 cycles
    step_valid = 1'b1; dp_request_byte = 1'b1; dp_bits_needed_next = 4'hB;
    for (int i = 0; i < 5; i++) begin
      #2;
      chk("st_starved", starved, 1);
      chk("st_ready", step_ready, 0);
      chk("st_bn", bits_needed, 4'h8);
      next_cycle();
    end
    byte_valid = 1'b1; byte_data = 8'h3C;
    #2;
    chk("st_accept", byte_ready, 1);
    chk("st_ready_accept_cycle", step_ready, 0);
    next_cycle();
    byte_valid = 1'b0;
    #2;
    chk("st_done_ready", step_ready, 1);
    chk("st_done_load", value_load, 1);
    chk("st_done_byte", value_byte, 8'h3C);
    next_cycle();
    step_valid = 1'b0;
    #2;
    chk("st_bn_after", bits_needed, 4'hB);
    chk("st_count", byte_count, 5);

    // Start during a starved step, with a byte handshaking in the same cycle
    step_valid = 1'b1; dp_request_byte = 1'b1; dp_bits_needed_next = 4'h9;
    #2;
    chk("rs_pre_starved", starved, 1);
    start = 1'b1; byte_valid = 1'b1; byte_data = 8'h77;
    #2;
    chk("rs_ready", step_ready, 0);
    chk("rs_load", value_load, 0);
    next_cycle();
    start = 1'b0; step_valid = 1'b0; byte_valid = 1'b0;
    #2;
    chk("rs_bn", bits_needed, 4'h8);
    chk("rs_count", byte_count, 0);
    chk("rs_busy", busy, 1);
    chk("rs_buf_cleared", byte_ready, 1);

    // One init byte delivered, then start again mid-INIT
    byte_valid = 1'b1; byte_data = 8'h11;
    next_cycle();
    byte_valid = 1'b0;
    #2;
    chk("mi_load", value_load, 1);
    chk("mi_byte", value_byte, 8'h11);
    chk("mi_done", init_done, 0);
    next_cycle();
    start = 1'b1; byte_valid = 1'b1; byte_data = 8'h22;
    #2;
    chk("mi_start_load", value_load, 0);
    next_cycle();
    start = 1'b0; byte_valid = 1'b0;
    #2;
    chk("mi_count", byte_count, 0);
    chk("mi_bn", bits_needed, 4'h8);
    run_init(8'h01, 8'h02, 8'h03);
    #2;
    chk("mi_run_count", byte_count, 3);
    chk("mi_run_busy", busy, 0);

    // Drive byte_count to 255 with back-to-back request steps
    step_valid = 1'b1; dp_request_byte = 1'b1; dp_bits_needed_next = 4'h8;
    byte_valid = 1'b1;
    commits = 0;
    for (int cyc = 0; cyc < 2000 && commits < 252; cyc++) begin
      byte_data = 8'(cyc);
      #2;
      if (step_ready) commits++;
      next_cycle();
    end
    step_valid = 1'b0; byte_valid = 1'b0;
    #2;
    chk("wrap_commits", commits, 252);
    chk("wrap_pre_count", byte_count, 8'hFF);

    // One more delivered byte wraps the counter
    byte_valid = 1'b1; byte_data = 8'h99;
    next_cycle();
    byte_valid = 1'b0;
    step_valid = 1'b1; dp_request_byte = 1'b1; dp_bits_needed_next = 4'h9;
    #2;
    chk("wrap_load", value_load, 1);
    chk("wrap_byte", value_byte, 8'h99);
    chk("wrap_ready", step_ready, 1);
    next_cycle();
    step_valid = 1'b0;
    #2;
    chk("wrap_count", byte_count, 0);
    chk("wrap_bn", bits_needed, 4'h9);
    chk("wrap_busy", busy, 0);
    chk("wrap_no_load", value_load, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
